// File: rtl/mux_logic_pkg.sv
// Shared definitions for mux_logic_unit: op encodings and the per-op mapping
// onto a 2:1 mux (select source plus the two data-input sources).
package mux_logic_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_BUF  = 3'd7;

    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_ONE,
        SRC_A,
        SRC_NOT_A
    } src_e;

    typedef struct packed {
        logic sel_a;  // 1: mux select is a[i], 0: mux select is b[i]
        src_e d0;
        src_e d1;
    } mux_cfg_t;

    // Each two-input gate is a mux on b[i] choosing between constants and a[i]/~a[i].
    function automatic mux_cfg_t op_cfg(input logic [2:0] op);
        mux_cfg_t cfg;
        cfg = '{sel_a: 1'b0, d0: SRC_ZERO, d1: SRC_A};
        case (op)
            OP_AND:  cfg = '{sel_a: 1'b0, d0: SRC_ZERO,  d1: SRC_A};
            OP_OR:   cfg = '{sel_a: 1'b0, d0: SRC_A,     d1: SRC_ONE};
            OP_NAND: cfg = '{sel_a: 1'b0, d0: SRC_ONE,   d1: SRC_NOT_A};
            OP_NOR:  cfg = '{sel_a: 1'b0, d0: SRC_NOT_A, d1: SRC_ZERO};
            OP_XOR:  cfg = '{sel_a: 1'b0, d0: SRC_A,     d1: SRC_NOT_A};
            OP_XNOR: cfg = '{sel_a: 1'b0, d0: SRC_NOT_A, d1: SRC_A};
            OP_NOT:  cfg = '{sel_a: 1'b1, d0: SRC_ONE,   d1: SRC_ZERO};
            OP_BUF:  cfg = '{sel_a: 1'b1, d0: SRC_ZERO,  d1: SRC_ONE};
            default: cfg = '{sel_a: 1'b1, d0: SRC_ZERO,  d1: SRC_ONE};
        endcase
        return cfg;
    endfunction

    function automatic logic src_bit(input src_e src, input logic a_bit);
        case (src)
            SRC_ZERO:  return 1'b0;
            SRC_ONE:   return 1'b1;
            SRC_A:     return a_bit;
            SRC_NOT_A: return ~a_bit;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mux2to1.sv
// Single-bit 2:1 multiplexer; the only logic cell on the result datapath.
module mux2to1 (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_logic_unit.sv
// Mux-built bitwise logic unit with valid/ready handshakes, one-cycle latency,
// accumulate (chain) mode and a saturating completed-result counter.
module mux_logic_unit
    import mux_logic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             red_xor,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             valid_q;
    logic [WIDTH-1:0] y_q;
    logic             red_q;
    logic [CNT_W-1:0] count_q;

    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] mux_y;
    mux_cfg_t         cfg;

    assign in_ready = !valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = valid_q && out_ready;

    // In chain mode A is the registered result, which is also the value being
    // consumed when an output and input transfer coincide.
    assign op_a = acc_en ? y_q : a;
    assign cfg  = op_cfg(op);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic sel;
        logic d0;
        logic d1;

        assign sel = cfg.sel_a ? op_a[i] : b[i];
        assign d0  = src_bit(cfg.d0, op_a[i]);
        assign d1  = src_bit(cfg.d1, op_a[i]);

        mux2to1 u_mux (
            .sel (sel),
            .d0  (d0),
            .d1  (d1),
            .y   (mux_y[i])
        );
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            y_q     <= '0;
            red_q   <= 1'b0;
            count_q <= '0;
        end else begin
            if (in_xfer) begin
                valid_q <= 1'b1;
                y_q     <= mux_y;
                red_q   <= ^mux_y;
            end else if (out_xfer) begin
                valid_q <= 1'b0;
            end

            if (out_xfer && (count_q != CNT_MAX)) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign out_valid = valid_q;
    assign y         = y_q;
    assign red_xor   = red_q;
    assign op_count  = count_q;

endmodule

// File: doc/mux_logic_unit.md
MUX_LOGIC_UNIT -- requirements
Module: mux_logic_unit

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit width (>=1).
REQ-002 Parameter: CNT_W, default 16, width of the completed-operation counter (>=1).
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: in_valid  input  1  operand/op bundle valid.
REQ-006 Port: in_ready  output  1  unit accepts bundle this cycle.
REQ-007 Port: a  input  WIDTH  operand A.
REQ-008 Port: b  input  WIDTH  operand B.
REQ-009 Port: op  input  3  gate select (encoding REQ-013).
REQ-010 Port: acc_en  input  1  chain mode; substitute last result for A.
REQ-011 Port: out_valid / out_ready  output / input  1 each  result handshake.
REQ-012 Port: y  output  WIDTH  result; red_xor  output  1  XOR-reduction of y; op_count  output  CNT_W  completed results.

Function
REQ-013 op encoding SHALL be: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A (B ignored), 7 BUF A (B ignored).
REQ-014 Every result bit SHALL be produced by a 2:1 mux whose select is b[i] (ops 0-5) or a[i] (ops 6-7), data inputs being constants 0/1, a[i] or ~a[i]; no direct gate operators on the datapath.
REQ-015 Input transfer SHALL occur when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational, no in_valid dependency).
REQ-016 Latency SHALL be one cycle: the result of a transfer in cycle N appears on y, with out_valid=1, in cycle N+1.
REQ-017 While out_valid && !out_ready, y, red_xor and out_valid SHALL hold stable and in_ready SHALL be 0.
REQ-018 Output handshake (out_valid && out_ready) with no simultaneous input transfer SHALL clear out_valid next cycle; y SHALL retain its last value.
REQ-019 Simultaneous output and input transfer SHALL keep out_valid=1 and load the new result; full throughput of one result per cycle.
REQ-020 red_xor SHALL be registered together with y and always equal ^y.
REQ-021 With acc_en=1 at transfer, operand A SHALL be the current y register (regardless of out_valid); after reset that value is 0.
REQ-022 With acc_en=1 during a simultaneous output+input transfer, A SHALL be the y being consumed in that cycle.
REQ-023 op_count SHALL increment by 1 on each output handshake and saturate at 2^CNT_W-1 (no wrap).
REQ-024 in_valid dropping without transfer SHALL not change state; no requirement on a/b/op stability before transfer.

Reset
REQ-025 rst_n low SHALL immediately force out_valid=0, y=0, red_xor=0, op_count=0, independent of clk, including mid-transfer or mid-stall.
REQ-026 in_ready SHALL be 1 during and after reset (out_valid=0); first transfer allowed on first rising edge with rst_n high.

Structure
REQ-027 Op encodings (OP_AND..OP_BUF) SHALL be localparams in shared package mux_logic_pkg, used by RTL and bench.
REQ-028 The per-bit 2:1 mux SHALL be sub-module mux2to1, instantiated WIDTH times via generate; one output register stage, no other sub-modules.

Verification
REQ-029 WIDTH=8, a=8'hCC, b=8'hAA, ops 0..7 in consecutive cycles, out_ready=1 -> y = 88, EE, 77, 11, 66, 99, 33, CC, one per cycle after 1-cycle latency.
REQ-030 a=8'hA5, b=8'h0F, op=XOR -> y=8'hAA, red_xor=0, out_valid=1 next cycle; op_count=1 after handshake.
REQ-031 out_ready=0 with result pending, second bundle offered -> in_ready=0, y stays 8'hAA 5 cycles; out_ready=1 -> second result next cycle, nothing lost.
REQ-032 XOR A5^0F (y=AA), then acc_en=1, op=XOR, b=8'hFF -> y=8'h55; then acc_en=1, op=NOT -> y=8'hAA.
REQ-033 CNT_W=2, 5 output handshakes -> op_count=3 held.
REQ-034 rst_n pulled low between clock edges while out_valid=1, out_ready=0 -> out_valid, y, op_count read 0 before the next clk edge; in_ready=1.
